// File: rtl/lutram_march_ctrl_if.sv
// RAM-side bus of the LUTRAM March C- BIST controller.
// master = controller, slave = RAM128X1D-class primitive or model.
interface lutram_march_ctrl_if #(
   parameter int ADDR_W = 7
);
   logic [ADDR_W-1:0] ram_a_o;
   logic [ADDR_W-1:0] ram_dpra_o;
   logic              ram_d_o;
   logic              ram_we_o;
   logic              ram_spo_i;
   logic              ram_dpo_i;

   modport master (
      output ram_a_o,
      output ram_dpra_o,
      output ram_d_o,
      output ram_we_o,
      input  ram_spo_i,
      input  ram_dpo_i
   );

   modport slave (
      input  ram_a_o,
      input  ram_dpra_o,
      input  ram_d_o,
      input  ram_we_o,
      output ram_spo_i,
      output ram_dpo_i
   );
endinterface

// File: rtl/lutram_march_ctrl.sv
// March C- BIST sequencer for one 128x1 dual-port LUTRAM.
// Define LUTRAM_MARCH_DPO_CHECK_EN to also compare the DPO read port.
module lutram_march_ctrl #(
   parameter int ADDR_W = 7
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              fail_o,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [2:0]        fail_elem_o,
   output logic              fail_port_o,
   lutram_march_ctrl_if.master ram
);

   typedef enum logic [2:0] {
      IDLE, M0, M1, M2, M3, M4, M5, DONE
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic              last_up, last_dn;
   logic              we, d, exp, chk;
   logic [2:0]        elem;
   logic              start_go;
   logic              busy_nxt, done_nxt;
   logic              spo_err, dpo_err, hit, port_hit;

   assign last_up  = &addr;
   assign last_dn  = ~|addr;
   assign start_go = start_i && (state == IDLE || state == DONE);

   // Next-state, address walk and per-element write/expect decode.
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      we        = 1'b0;
      d         = 1'b0;
      exp       = 1'b0;
      chk       = 1'b0;
      elem      = 3'd0;
      unique case (state)
         IDLE, DONE: begin
            if (start_i) begin
               state_nxt = M0;
               addr_nxt  = '0;
            end
         end
         M0: begin
            we       = 1'b1;
            addr_nxt = addr + 1'b1;
            if (last_up) state_nxt = M1;
         end
         M1: begin
            we       = 1'b1;
            d        = 1'b1;
            chk      = 1'b1;
            elem     = 3'd1;
            addr_nxt = addr + 1'b1;
            if (last_up) state_nxt = M2;
         end
         M2: begin
            we   = 1'b1;
            exp  = 1'b1;
            chk  = 1'b1;
            elem = 3'd2;
            // M3 descends from the top, so hold the last address.
            if (last_up) state_nxt = M3;
            else addr_nxt = addr + 1'b1;
         end
         M3: begin
            we       = 1'b1;
            d        = 1'b1;
            chk      = 1'b1;
            elem     = 3'd3;
            addr_nxt = addr - 1'b1;
            if (last_dn) state_nxt = M4;
         end
         M4: begin
            we   = 1'b1;
            exp  = 1'b1;
            chk  = 1'b1;
            elem = 3'd4;
            // M5 ascends from zero, so hold the last address.
            if (last_dn) state_nxt = M5;
            else addr_nxt = addr - 1'b1;
         end
         M5: begin
            chk      = 1'b1;
            elem     = 3'd5;
            addr_nxt = addr + 1'b1;
            if (last_up) state_nxt = DONE;
         end
         default: begin
            state_nxt = IDLE;
            addr_nxt  = '0;
         end
      endcase
   end

   assign busy_nxt = state_nxt inside {M0, M1, M2, M3, M4, M5};
   assign done_nxt = state_nxt == DONE;

   // Read compare is against the asynchronous read of the current address,
   // before this cycle's write lands on the clock edge.
   assign spo_err = chk && (ram.ram_spo_i != exp);
`ifdef LUTRAM_MARCH_DPO_CHECK_EN
   assign dpo_err  = chk && (ram.ram_dpo_i != exp);
   assign port_hit = ~spo_err;
`else
   logic unused_dpo;
   assign unused_dpo = ram.ram_dpo_i;
   assign dpo_err    = 1'b0;
   assign port_hit   = 1'b0;
`endif
   assign hit = spo_err || dpo_err;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // Address counter, status flags and first-failure capture.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr        <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         fail_o      <= 1'b0;
         fail_addr_o <= '0;
         fail_elem_o <= 3'd0;
         fail_port_o <= 1'b0;
      end else begin
         addr   <= addr_nxt;
         busy_o <= busy_nxt;
         done_o <= done_nxt;
         if (start_go) begin
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_elem_o <= 3'd0;
            fail_port_o <= 1'b0;
         end else if (hit && !fail_o) begin
            fail_o      <= 1'b1;
            fail_addr_o <= addr;
            fail_elem_o <= elem;
            fail_port_o <= port_hit;
         end
      end
   end

   assign ram.ram_a_o    = addr;
   assign ram.ram_dpra_o = addr;
   assign ram.ram_we_o   = we;
   assign ram.ram_d_o    = d;

endmodule

// File: tb/tb_lutram_march_ctrl.sv
// Directed bench for lutram_march_ctrl with a behavioral 128x1 RAM
// that can inject stuck-at faults on one cell or on the DPO port only.
module tb_lutram_march_ctrl;
   localparam int ADDR_W = 7;
   localparam int DEPTH  = 128;
   localparam int RUN    = 6 * DEPTH;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              start_i;
   logic              busy_o, done_o, fail_o, fail_port_o;
   logic [ADDR_W-1:0] fail_addr_o;
   logic [2:0]        fail_elem_o;

   int asserts = 0;
   int fails   = 0;

   logic              cell_en = 1'b0;
   logic [ADDR_W-1:0] cell_addr = '0;
   logic              cell_val = 1'b0;
   logic              dpo_en = 1'b0;
   logic [ADDR_W-1:0] dpo_addr = '0;
   logic              dpo_val = 1'b0;

   logic mem [DEPTH];
   logic spo, dpo;

   lutram_march_ctrl_if #(.ADDR_W(ADDR_W)) ram_if ();

   lutram_march_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .fail_o      (fail_o),
      .fail_addr_o (fail_addr_o),
      .fail_elem_o (fail_elem_o),
      .fail_port_o (fail_port_o),
      .ram         (ram_if.master)
   );

   always #5 clk = ~clk;

   // Behavioral RAM: synchronous write, asynchronous reads.
   always @(posedge clk)
      if (ram_if.ram_we_o) mem[ram_if.ram_a_o] <= ram_if.ram_d_o;

   // Read ports with optional stuck-at overrides.
   always_comb begin
      spo = mem[ram_if.ram_a_o];
      dpo = mem[ram_if.ram_dpra_o];
      if (cell_en && ram_if.ram_a_o == cell_addr) spo = cell_val;
      if (cell_en && ram_if.ram_dpra_o == cell_addr) dpo = cell_val;
      if (dpo_en && ram_if.ram_dpra_o == dpo_addr) dpo = dpo_val;
   end

   assign ram_if.ram_spo_i = spo;
   assign ram_if.ram_dpo_i = dpo;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      asserts++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected bus values in cycle k of a run, straight from March C-.
   task automatic exp_at(input int k, output logic [ADDR_W-1:0] a,
                         output logic we, output logic d);
      int e, i;
      e  = k / DEPTH;
      i  = k % DEPTH;
      a  = (e == 3 || e == 4) ? ADDR_W'(DEPTH - 1 - i) : ADDR_W'(i);
      we = (e < 5);
      d  = (e == 1 || e == 3);
   endtask

   // Start a run, track the bus cycle by cycle, wait for done (bounded).
   task automatic run(input string tag, input int restart_at);
      int cyc, bad;
      logic [ADDR_W-1:0] ea;
      logic ew, ed;
      cyc = 0;
      bad = 0;
      @(negedge clk);
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      check({tag, ":busy_rise"}, busy_o, 1);
      check({tag, ":done_clr"}, done_o, 0);
      while (!done_o && cyc < 2 * RUN) begin
         if (cyc < RUN) begin
            exp_at(cyc, ea, ew, ed);
            if (ram_if.ram_a_o !== ea || ram_if.ram_dpra_o !== ea ||
                ram_if.ram_we_o !== ew || ram_if.ram_d_o !== ed ||
                busy_o !== 1'b1)
               bad++;
         end
         start_i = (cyc == restart_at);
         @(posedge clk);
         #1;
         cyc++;
      end
      start_i = 1'b0;
      check({tag, ":cycles"}, cyc, RUN);
      check({tag, ":bus_seq_bad"}, bad, 0);
      check({tag, ":busy_fall"}, busy_o, 0);
      check({tag, ":we_idle"}, ram_if.ram_we_o, 0);
   endtask

   initial begin
      rst_i   = 1'b1;
      start_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst:busy", busy_o, 0);
      check("rst:done", done_o, 0);
      check("rst:fail", fail_o, 0);
      check("rst:fail_addr", fail_addr_o, 0);
      check("rst:fail_elem", fail_elem_o, 0);
      check("rst:fail_port", fail_port_o, 0);
      check("rst:a", ram_if.ram_a_o, 0);
      check("rst:dpra", ram_if.ram_dpra_o, 0);
      check("rst:we", ram_if.ram_we_o, 0);
      check("rst:d", ram_if.ram_d_o, 0);
      @(negedge clk);
      rst_i = 1'b0;

      // Fault-free pass.
      run("clean", -1);
      check("clean:fail", fail_o, 0);
      repeat (5) @(posedge clk);
      #1;
      check("clean:done_hold", done_o, 1);
      check("clean:busy_hold", busy_o, 0);

      // Cell 5 stuck-at-1: first read r0 in M1 fails on both ports.
      cell_en   = 1'b1;
      cell_addr = 7'd5;
      cell_val  = 1'b1;
      run("sa1_5", -1);
      check("sa1_5:fail", fail_o, 1);
      check("sa1_5:addr", fail_addr_o, 5);
      check("sa1_5:elem", fail_elem_o, 1);
      check("sa1_5:port", fail_port_o, 0);

      // Cell 127 stuck-at-0: first failure is r1 in M2 at the top.
      cell_addr = 7'd127;
      cell_val  = 1'b0;
      run("sa0_127", -1);
      check("sa0_127:fail", fail_o, 1);
      check("sa0_127:addr", fail_addr_o, 127);
      check("sa0_127:elem", fail_elem_o, 2);
      check("sa0_127:port", fail_port_o, 0);
      cell_en = 1'b0;

      // DPO-only stuck-at-1 at address 10.
      dpo_en   = 1'b1;
      dpo_addr = 7'd10;
      dpo_val  = 1'b1;
      run("dpo_10", -1);
`ifdef LUTRAM_MARCH_DPO_CHECK_EN
      check("dpo_10:fail", fail_o, 1);
      check("dpo_10:addr", fail_addr_o, 10);
      check("dpo_10:elem", fail_elem_o, 1);
      check("dpo_10:port", fail_port_o, 1);
`else
      check("dpo_10:fail", fail_o, 0);
      check("dpo_10:addr", fail_addr_o, 0);
      check("dpo_10:port", fail_port_o, 0);
`endif
      dpo_en = 1'b0;

      // Start re-pulsed mid-run is ignored.
      run("restart", 200);
      check("restart:fail", fail_o, 0);

      // Reset at cycle 300 of a failing run, then a clean pass.
      cell_en   = 1'b1;
      cell_addr = 7'd5;
      cell_val  = 1'b1;
      @(negedge clk);
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      check("mid:busy", busy_o, 1);
      check("mid:fail", fail_o, 1);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst:busy", busy_o, 0);
      check("mid_rst:we", ram_if.ram_we_o, 0);
      check("mid_rst:done", done_o, 0);
      check("mid_rst:fail", fail_o, 0);
      check("mid_rst:fail_addr", fail_addr_o, 0);
      check("mid_rst:fail_elem", fail_elem_o, 0);
      check("mid_rst:a", ram_if.ram_a_o, 0);
      @(posedge clk);
      #1;
      check("mid_rst:we_held", ram_if.ram_we_o, 0);
      @(negedge clk);
      rst_i   = 1'b0;
      cell_en = 1'b0;
      run("post_rst", -1);
      check("post_rst:fail", fail_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               asserts, fails);
      $finish;
   end
endmodule
